// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared definitions for the load/store unit: RV32I funct3
//               width/sign codes, FSM state encoding, lane masks and the
//               width/alignment legality helper.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  // RV32I load/store width and sign codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Right-aligned lane masks, shifted into place by the byte offset
  localparam logic [31:0] LANE_MASK_B = 32'h0000_00FF;
  localparam logic [31:0] LANE_MASK_H = 32'h0000_FFFF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    WR     = 3'd3,
    RESP   = 3'd4
  } lsu_state_t;

  // True when funct3 is illegal for the access direction or the low address
  // bits are misaligned for the access width. Range checking is done by the
  // caller because it depends on the memory depth.
  function automatic logic f3_align_err(input logic       we,
                                        input logic [2:0] f3,
                                        input logic [1:0] lo);
    logic err;
    case (f3)
      F3_B:    err = 1'b0;
      F3_H:    err = lo[0];
      F3_W:    err = |lo;
      F3_BU:   err = we;            // unsigned forms exist only for loads
      F3_HU:   err = we | lo[0];
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Combinational lane handling for the load/store unit.
//               Extracts and sign/zero-extends a byte or half from a memory
//               word, and merges right-aligned store data into a word.
// Revision    : 1.0 - initial release
// Ports       : word      - memory word read from the data memory
//               byte_off  - address bits [1:0] selecting the lane
//               funct3    - RV32I width/sign code
//               wdata     - right-aligned store data
//               load_data - extended load result
//               merged    - word with the store lane replaced
// ============================================================================
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [4:0]  w_shamt;
  logic [31:0] w_shifted;
  logic [31:0] w_mask;

  assign w_shamt   = {byte_off, 3'b000};
  assign w_shifted = word >> w_shamt;

  always_comb begin
    load_data = w_shifted;        // word access: byte_off is 0, no shift
    case (funct3)
      F3_B:  load_data = {{24{w_shifted[7]}},  w_shifted[7:0]};
      F3_H:  load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_BU: load_data = {24'h0, w_shifted[7:0]};
      F3_HU: load_data = {16'h0, w_shifted[15:0]};
      default: load_data = w_shifted;
    endcase
  end

  // funct3[1:0] == 00 is a byte store; anything else reaching here is a half
  assign w_mask = ((funct3[1:0] == 2'b00) ? LANE_MASK_B : LANE_MASK_H) << w_shamt;
  assign merged = (word & ~w_mask) | ((wdata << w_shamt) & w_mask);

endmodule : lsu_align
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Single-outstanding RV32I load/store unit in front of a word
//               memory with combinational read. Sub-word stores are done as
//               read-modify-write. Illegal, misaligned or out-of-range
//               requests complete with resp_err and never write memory.
// Revision    : 1.0 - initial release
// Ports       : clk, rst                 - clock, async active-high reset
//               req_valid/req_ready      - request handshake
//               req_we, req_funct3,
//               req_addr, req_wdata      - request fields
//               resp_valid, resp_rdata,
//               resp_err                 - one-cycle completion
//               mem_we, mem_waddr,
//               mem_wdata, mem_raddr,
//               mem_rdata                - data memory interface
// ============================================================================
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_SIZE = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_raddr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  lsu_state_t  r_state;
  logic [31:0] r_addr;
  logic [2:0]  r_funct3;
  logic [31:0] r_wdata;
  logic        r_we;

  logic        w_req_err;
  logic [31:0] w_load_data;
  logic [31:0] w_merged;

  assign w_req_err = f3_align_err(req_we, req_funct3, req_addr[1:0]) |
                     ({2'b00, req_addr[31:2]} >= 32'(MEM_SIZE));

  // rst is folded in so the unit never advertises readiness while held
  assign req_ready = (r_state == IDLE) & ~rst;

  // Both memory ports point at the latched word, so reads in LOAD/RMW_RD
  // and the write in WR all target the accepted address.
  assign mem_raddr = {r_addr[31:2], 2'b00};
  assign mem_waddr = {r_addr[31:2], 2'b00};

  lsu_align u_align (
    .word      (mem_rdata),
    .byte_off  (r_addr[1:0]),
    .funct3    (r_funct3),
    .wdata     (r_wdata),
    .load_data (w_load_data),
    .merged    (w_merged)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_funct3   <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_addr   <= req_addr;
            r_funct3 <= req_funct3;
            r_wdata  <= req_wdata;
            r_we     <= req_we;
            if (w_req_err) begin
              r_state    <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (!req_we) begin
              r_state <= LOAD;
            end else if (req_funct3 == F3_W) begin
              // Full-word store needs no read, go straight to the write
              r_state   <= WR;
              mem_we    <= 1'b1;
              mem_wdata <= req_wdata;
            end else begin
              r_state <= RMW_RD;
            end
          end
        end

        // Both states consume mem_rdata this cycle; r_we tells them apart
        LOAD, RMW_RD: begin
          if (r_we) begin
            r_state   <= WR;
            mem_we    <= 1'b1;
            mem_wdata <= w_merged;
          end else begin
            r_state    <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= w_load_data;
          end
        end

        WR: begin
          r_state    <= RESP;
          mem_we     <= 1'b0;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end

        RESP: begin
          r_state    <= IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end

        default: begin
          r_state    <= IDLE;
          mem_we     <= 1'b0;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule : load_store_unit
`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter MEM_SIZE, default 1024, meaning the data memory depth in 32-bit words.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port req_valid, input, 1 bit: core presents a memory request.
REQ-005 The block SHALL have port req_ready, output, 1 bit: unit accepts a request this cycle.
REQ-006 The block SHALL have port req_we, input, 1 bit: 1 means store, 0 means load.
REQ-007 The block SHALL have port req_funct3, input, 3 bits: RV32I width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-008 The block SHALL have port req_addr, input, 32 bits: byte address.
REQ-009 The block SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-010 The block SHALL have port resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-011 The block SHALL have port resp_rdata, output, 32 bits: extended load result, 0 for stores and errors.
REQ-012 The block SHALL have port resp_err, output, 1 bit: misaligned, illegal funct3, or out-of-range request.
REQ-013 The block SHALL have port mem_we, output, 1 bit, to the data memory write enable.
REQ-014 The block SHALL have ports mem_waddr and mem_raddr, output, 32 bits each: word-aligned byte address, bits [1:0] = 0.
REQ-015 The block SHALL have port mem_wdata, output, 32 bits: full merged word.
REQ-016 The block SHALL have port mem_rdata, input, 32 bits: memory read data, combinational from mem_raddr within the same cycle.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, RMW_RD, WR and RESP; req_ready = 1 only in IDLE.
REQ-018 In IDLE with req_valid = 1, the unit SHALL latch addr, funct3, wdata and we at the clock edge and move to RESP (error), LOAD (load), WR (SW), or RMW_RD (SB/SH).
REQ-019 An error SHALL be detected on: H with addr[0] != 0; W with addr[1:0] != 0; funct3 of 011, 110 or 111; store with funct3 100 or 101; or addr[31:2] >= MEM_SIZE.
REQ-020 In LOAD, the unit SHALL drive mem_raddr, select the byte/half lane by addr[1:0], sign-extend (B, H) or zero-extend (BU, HU), register the result, and move to RESP.
REQ-021 In RMW_RD, the unit SHALL drive mem_raddr, merge req_wdata[7:0] or [15:0] into the addressed lane of mem_rdata (other lanes unchanged), register the merged word, and move to WR.
REQ-022 In WR, mem_we SHALL be 1 for exactly one cycle with mem_waddr and mem_wdata (merged word, or latched wdata for SW), then the FSM SHALL move to RESP.
REQ-023 In RESP, resp_valid SHALL be 1 for one cycle with resp_err/resp_rdata, then the FSM SHALL move to IDLE; there is no response back-pressure.
REQ-024 Latency from acceptance edge to resp_valid SHALL be: error 1 cycle, load 2, SW 2, SB/SH 3.
REQ-025 mem_we SHALL be 0 outside WR; an erroneous request SHALL never assert mem_we.
REQ-026 req_valid in non-IDLE states SHALL be ignored and SHALL not alter latched state.

Reset
REQ-027 rst SHALL asynchronously force state to IDLE and clear all latched registers to 0.
REQ-028 While rst = 1, outputs SHALL be: req_ready 0, resp_valid 0, resp_err 0, resp_rdata 0, mem_we 0, addresses 0, mem_wdata 0.
REQ-029 Reset during RMW_RD or WR SHALL abort the store without any memory write, and SHALL not produce a response.

Structure
REQ-030 Package lsu_pkg SHALL hold the funct3 encodings, the FSM state enum and the lane-mask constants.
REQ-031 The combinational sub-module lsu_align SHALL perform lane extract/extend and lane merge; the FSM SHALL stay in load_store_unit.

Verification
REQ-032 Scenario: word 0x10 = 0x80FF7F01; LB addr 0x13 -> resp_rdata 0xFFFFFF80 two cycles after acceptance, resp_err 0.
REQ-033 Scenario: same word; LHU addr 0x12 -> 0x000080FF; LH addr 0x10 -> 0x00007F01.
REQ-034 Scenario: SB addr 0x11 with wdata 0x000000AA -> single mem_we pulse with mem_wdata 0x80FFAA01, resp_valid three cycles after acceptance.
REQ-035 Scenario: LW addr 0x0E, and SW addr 0x00001000 with MEM_SIZE 1024 -> resp_err 1 after one cycle, mem_we never asserted.
REQ-036 Scenario: SH addr 0x10, rst asserted during RMW_RD -> no mem_we, no resp_valid, req_ready 1 after rst falls.
